// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store port sequencer.
// States, RV32 funct3 access codes, and access size / byte-mask decode.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ1 = 3'd1,
    CAP1 = 3'd2,
    GAP  = 3'd3,
    REQ2 = 3'd4,
    CAP2 = 3'd5,
    RESP = 3'd6
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size in bytes; 0 flags an unsupported code.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_bytes = 3'd1;
      F3_H, F3_HU: size_bytes = 3'd2;
      F3_W:        size_bytes = 3'd4;
      default:     size_bytes = 3'd0;
    endcase
  endfunction

  // Byte-enable pattern of an access at offset 0.
  function automatic logic [3:0] basemask(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: basemask = 4'b0001;
      F3_H, F3_HU: basemask = 4'b0011;
      F3_W:        basemask = 4'b1111;
      default:     basemask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load result formatter: aligns a two-word window by byte offset, then
// truncates and sign/zero-extends to the access size.
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] sh_s;

  assign sh_s = 32'(data >> {offset, 3'b000});

  // Size selection and extension of the aligned bytes.
  always_comb begin
    result = 32'h0000_0000;
    case (funct3)
      F3_B:    result = {{24{sh_s[7]}}, sh_s[7:0]};
      F3_H:    result = {{16{sh_s[15]}}, sh_s[15:0]};
      F3_W:    result = sh_s;
      F3_BU:   result = {24'h00_0000, sh_s[7:0]};
      F3_HU:   result = {16'h0000, sh_s[15:0]};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_port.sv
// Load/store sequencer in front of one synchronous-read RAM port.
// Define LSU_SPLIT_EN to split word-crossing accesses into two RAM accesses.
module lsu_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int SPLIT_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  output logic              mem_cen,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  lsu_state_e  state_r;
  logic [1:0]  off_r;
  logic [2:0]  funct3_r;
  logic        we_r;

  logic [1:0]  off_s;
  logic [2:0]  sz_s;
  logic [3:0]  bm_s;
  logic [3:0]  mask_lo_s;
  logic [31:0] wdata_lo_s;
  logic        illegal_s;
  logic        err_s;
  logic [63:0] fmt_data_s;
  logic [31:0] fmt_out_s;

  assign off_s = req_addr[1:0];
  assign sz_s  = size_bytes(req_funct3);
  assign bm_s  = basemask(req_funct3);

  // Legal codes: all five for loads, only B/H/W for stores.
  always_comb begin
    illegal_s = 1'b1;
    case (req_funct3)
      F3_B, F3_H, F3_W: illegal_s = 1'b0;
      F3_BU, F3_HU:     illegal_s = req_we;
      default:          illegal_s = 1'b1;
    endcase
  end

`ifdef LSU_SPLIT_EN
  logic              split_s;
  logic [7:0]        mask8_s;
  logic [63:0]       wdata64_s;
  logic              split_r;
  logic [ADDR_W-1:0] addr2_r;
  logic [3:0]        mask2_r;
  logic [31:0]       wdata2_r;
  logic [31:0]       lo_word_r;
  logic [1:0]        gap_cnt_r;

  assign mask8_s    = {4'h0, bm_s} << off_s;
  assign wdata64_s  = {32'h0000_0000, req_wdata} << {off_s, 3'b000};
  assign mask_lo_s  = mask8_s[3:0];
  assign wdata_lo_s = wdata64_s[31:0];
  assign split_s    = (({1'b0, off_s} + sz_s) > 3'd4);
  assign err_s      = illegal_s;
  assign fmt_data_s = (state_r == CAP2) ? {mem_rdata, lo_word_r}
                                        : {32'h0000_0000, mem_rdata};
`else
  logic misal_s;

  assign mask_lo_s  = bm_s << off_s;
  assign wdata_lo_s = req_wdata << {off_s, 3'b000};
  assign err_s      = illegal_s | misal_s;
  assign fmt_data_s = {32'h0000_0000, mem_rdata};

  // Without splitting, any access not naturally aligned is rejected.
  always_comb begin
    misal_s = 1'b0;
    case (sz_s)
      3'd4:    misal_s = (off_s != 2'b00);
      3'd2:    misal_s = off_s[0];
      default: misal_s = 1'b0;
    endcase
  end
`endif

  lsu_load_fmt u_fmt (
    .data   (fmt_data_s),
    .offset (off_r),
    .funct3 (funct3_r),
    .result (fmt_out_s)
  );

  // Sequencer FSM with all port outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      off_r     <= 2'b00;
      funct3_r  <= 3'b000;
      we_r      <= 1'b0;
      req_ready <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= 4'h0;
      mem_wdata <= 32'h0000_0000;
      mem_cen   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
`ifdef LSU_SPLIT_EN
      split_r   <= 1'b0;
      addr2_r   <= '0;
      mask2_r   <= 4'h0;
      wdata2_r  <= 32'h0000_0000;
      lo_word_r <= 32'h0000_0000;
      gap_cnt_r <= 2'b00;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            off_r     <= off_s;
            funct3_r  <= req_funct3;
            we_r      <= req_we;
            if (err_s) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0000_0000;
              state_r   <= RESP;
            end else begin
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wmask <= req_we ? mask_lo_s : 4'h0;
              mem_wdata <= wdata_lo_s;
              mem_cen   <= 1'b1;
`ifdef LSU_SPLIT_EN
              split_r   <= split_s;
              addr2_r   <= {req_addr[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};
              mask2_r   <= req_we ? mask8_s[7:4] : 4'h0;
              wdata2_r  <= wdata64_s[63:32];
`endif
              state_r   <= REQ1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        REQ1: begin
          mem_cen   <= 1'b0;
          mem_wmask <= 4'h0;
          state_r   <= CAP1;
        end
        CAP1: begin
`ifdef LSU_SPLIT_EN
          if (split_r) begin
            lo_word_r <= mem_rdata;
            if (SPLIT_WAIT > 0) begin
              gap_cnt_r <= 2'(SPLIT_WAIT - 1);
              state_r   <= GAP;
            end else begin
              mem_addr  <= addr2_r;
              mem_wmask <= mask2_r;
              mem_wdata <= wdata2_r;
              mem_cen   <= 1'b1;
              state_r   <= REQ2;
            end
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_r ? 32'h0000_0000 : fmt_out_s;
            state_r   <= RESP;
          end
`else
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= we_r ? 32'h0000_0000 : fmt_out_s;
          state_r   <= RESP;
`endif
        end
`ifdef LSU_SPLIT_EN
        GAP: begin
          if (gap_cnt_r == 2'b00) begin
            mem_addr  <= addr2_r;
            mem_wmask <= mask2_r;
            mem_wdata <= wdata2_r;
            mem_cen   <= 1'b1;
            state_r   <= REQ2;
          end else begin
            gap_cnt_r <= gap_cnt_r - 2'b01;
          end
        end
        REQ2: begin
          mem_cen   <= 1'b0;
          mem_wmask <= 4'h0;
          state_r   <= CAP2;
        end
        CAP2: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= we_r ? 32'h0000_0000 : fmt_out_s;
          state_r   <= RESP;
        end
`endif
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0000_0000;
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          mem_cen   <= 1'b0;
          mem_wmask <= 4'h0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_port.md
Name: lsu_port

Overview:
- Load/store sequencer sitting directly upstream of one data-memory port (a or b) of the dual-port data RAM; the core instantiates two.
- Accepts one load/store request per handshake and drives the RAM port (addr, byte wmask, lane-aligned wdata, cen).
- Absorbs the RAM's 1-cycle synchronous read latency and returns a sign/zero-extended load result or a store ack.

Parameters:
- ADDR_W, 32, request/memory address width
- SPLIT_WAIT, 0, extra idle cycles inserted between the two halves of a split access (0..3)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer on req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- mem_addr  out  ADDR_W  byte address to RAM (RAM uses [15:2]); low 2 bits always 0
- mem_wmask  out  4  byte write enables; 0 for reads
- mem_wdata  out  32  lane-shifted store data
- mem_cen  out  1  RAM port enable
- mem_rdata  in  32  RAM q, valid the cycle after mem_cen was high
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  qualified by rsp_valid: misaligned (when not splitting) or illegal funct3

Behaviour:
- All outputs are registered. Reset values: req_ready 0 while reset is asserted, 1 in IDLE after release; mem_* 0; rsp_* 0; state IDLE.
- States: IDLE, REQ1, CAP1, GAP, REQ2, CAP2, RESP.
- IDLE: on handshake, latch the request and compute offset = addr[1:0]. Set mem_addr = {addr[31:2],00}, mem_wmask = (we ? (basemask<<offset)[3:0] : 0), mem_wdata = (wdata<<8*offset)[31:0], mem_cen = 1. Go to REQ1.
  - basemask is 0001 for B, 0011 for H, 1111 for W.
- REQ1: RAM samples the port. Deassert mem_cen and mem_wmask. Go to CAP1.
- CAP1: capture mem_rdata as lo_word.
  - If split is required: go to GAP when SPLIT_WAIT>0, otherwise load the second-word outputs and go to REQ2.
  - Otherwise: register the response and go to RESP.
- Split required when offset + size_bytes > 4.
  - Second word: mem_addr = {addr[31:2]+1, 00}, full-width add, wraps at 2^ADDR_W.
  - Second word: mem_wmask = (basemask<<offset)[7:4].
  - Second word: mem_wdata = ({32'b0,wdata}<<8*offset)[63:32].
- GAP: count SPLIT_WAIT cycles, then behave as the exit of CAP1 into REQ2.
- REQ2 -> CAP2: capture hi_word, register the response, go to RESP.
- Load result: ({hi_word,lo_word} >> 8*offset) truncated to size, then sign-extended (B/H) or zero-extended (BU/HU).
  - hi_word = 0 if no split.
- RESP: rsp_valid = 1 for one cycle, go to IDLE; req_ready returns high the next cycle.
- Latency, accept at cycle T: unsplit rsp_valid at T+3; split rsp_valid at T+5+SPLIT_WAIT.
- Stores also wait through CAP states so the response timing is uniform.
- Illegal funct3 (011, 110, 111, or load-only codes with we=1): no RAM access. IDLE -> RESP directly, rsp_err = 1, rsp_valid at T+1.
- req_valid while not ready: ignored; requester holds the request.
- Reset mid-operation: state returns to IDLE and the response is dropped. A store whose REQ cycle already passed has been written; any pending second half is lost.

Optional Feature:
- Macro: LSU_SPLIT_EN.
- Defined: word-crossing accesses are split into two RAM accesses as above. Misaligned accesses within one word (e.g. H at offset 1) are single accesses.
- Undefined: any access with addr not a multiple of size_bytes produces rsp_err = 1 with no RAM access (rsp at T+1). GAP, REQ2 and CAP2 are not generated.

Decomposition:
- lsu_pkg: state enum lsu_state_e, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), size_bytes function, basemask function.
- Sub-module lsu_load_fmt: combinational 64-bit shift, truncation and extension for the load result; shared with the core's forwarding path.

Test Plan:
- LW at 0x0000_0100, RAM word 0xDEADBEEF -> rsp_valid at T+3, rsp_rdata 0xDEADBEEF, rsp_err 0, one RAM read at word 0x40.
- SB wdata 0x000000A5 at 0x102 -> mem_wmask 0100, mem_wdata 0x00A50000 in REQ1; a subsequent LBU at 0x102 returns 0x000000A5 and LB returns 0xFFFFFFA5.
- LH at 0x103 with word 0x40 = 0x80112233 and word 0x41 = 0x44556677, LSU_SPLIT_EN defined, SPLIT_WAIT 0 -> two reads (0x100, 0x104), rsp at T+5, rsp_rdata 0x00007780.
  - Undefined -> rsp_err 1 at T+1, mem_cen never high.
- SW 0x11223344 at 0xFFFF_FFFE, split -> first access addr 0xFFFFFFFC mask 1100 data 0x33440000; second access addr 0x00000000 mask 0011 data 0x00001122.
- funct3 011 load -> rsp_err 1 at T+1, rsp_rdata 0, no mem_cen. reset pulled low during CAP1 of a split -> all outputs 0 immediately, req_ready 1 after release, no second access.
- Back-to-back: req_valid held high for 4 LWs -> each handshake 4 cycles apart; req_ready low in REQ1..RESP.
